// File: rtl/max7219_cmd_scheduler.sv
// MAX7219 command scheduler: runs the power-up init sequence, then arbitrates
// shutdown, intensity and digit updates and shifts each as a 16-bit frame
// over the MAX7219 serial interface (din/cs/sclk).
module max7219_cmd_scheduler #(
  parameter int unsigned CLK_DIV       = 2,
  parameter logic [7:0]  SCAN_LIMIT    = 8'h00,
  parameter logic [3:0]  INTENSITY_RST = 4'h8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blank,
  input  logic       int_req,
  input  logic [3:0] int_level,
  output logic       int_ack,
  input  logic       dig_req,
  input  logic [3:0] dig_addr,
  input  logic [7:0] dig_data,
  output logic       dig_ack,
  output logic       din,
  output logic       cs,
  output logic       sclk,
  output logic       init_done,
  output logic       busy
);

  localparam logic [2:0] RESET_WAIT = 3'd0;
  localparam logic [2:0] INIT       = 3'd1;
  localparam logic [2:0] IDLE       = 3'd2;
  localparam logic [2:0] SHIFT      = 3'd3;
  localparam logic [2:0] GAP        = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic        sent_blank_q, sent_blank_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] sh_q, sh_d;

  logic        blank_grant, int_grant, dig_grant, dig_legal;
  logic        start;
  logic [15:0] load;
  logic [15:0] init_frame;

  // Fixed-priority arbitration, only while idle: shutdown mismatch > intensity > digit.
  always_comb begin
    blank_grant = 1'b0;
    int_grant   = 1'b0;
    dig_grant   = 1'b0;
    dig_legal   = (dig_addr != 4'd0) && (dig_addr <= 4'd8);
    if (state_q == IDLE) begin
      if (blank != sent_blank_q) blank_grant = 1'b1;
      else if (int_req)          int_grant   = 1'b1;
      else if (dig_req)          dig_grant   = 1'b1;
    end
  end

  assign int_ack = int_grant;
  assign dig_ack = dig_grant;

  // Init frame table, indexed by how many init frames have been launched.
  always_comb begin
    case (init_idx_q)
      3'd0:    init_frame = 16'h0F00;
      3'd1:    init_frame = 16'h0901;
      3'd2:    init_frame = {8'h0B, SCAN_LIMIT};
      3'd3:    init_frame = {8'h0A, 4'h0, INTENSITY_RST};
      default: init_frame = {8'h0C, 7'h00, ~blank};
    endcase
  end

  // Next-state logic: sequencing, frame launch and bit-level shifting.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    init_idx_d   = init_idx_q;
    init_done_d  = init_done_q;
    sent_blank_d = sent_blank_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    din_d        = din_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    div_d        = div_q;
    sh_d         = sh_q;
    start        = 1'b0;
    load         = 16'h0000;

    case (state_q)
      RESET_WAIT: begin
        if (wait_q == 2'd3) state_d = INIT;
        else                wait_d  = wait_q + 2'd1;
      end
      INIT: begin
        start      = 1'b1;
        load       = init_frame;
        init_idx_d = init_idx_q + 3'd1;
        if (init_idx_q == 3'd4) sent_blank_d = blank;
      end
      IDLE: begin
        if (blank_grant) begin
          start        = 1'b1;
          load         = {8'h0C, 7'h00, ~blank};
          sent_blank_d = blank;
        end else if (int_grant) begin
          start = 1'b1;
          load  = {8'h0A, 4'h0, int_level};
        end else if (dig_grant && dig_legal) begin
          start = 1'b1;
          load  = {4'h0, dig_addr, dig_data};
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
          end else if (bit_q == 4'd15) begin
            sclk_d  = 1'b0;
            cs_d    = 1'b1;
            din_d   = 1'b0;
            state_d = GAP;
          end else begin
            // Next bit goes out while sclk is low.
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            bit_d   = bit_q + 4'd1;
            din_d   = sh_q[15];
            sh_d    = {sh_q[14:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (init_done_q) begin
          state_d = IDLE;
        end else if (init_idx_q == 3'd5) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = INIT;
        end
      end
      default: state_d = RESET_WAIT;
    endcase

    // Frame launch: cs falls and the MSB is presented on the same edge.
    if (start) begin
      state_d = SHIFT;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      din_d   = load[15];
      sh_d    = {load[14:0], 1'b0};
      phase_d = 1'b0;
      bit_d   = 4'd0;
      div_d   = 8'd0;
    end
  end

  // Control and serial-output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_WAIT;
      wait_q       <= 2'd0;
      init_idx_q   <= 3'd0;
      init_done_q  <= 1'b0;
      sent_blank_q <= 1'b0;
      cs_q         <= 1'b1;
      sclk_q       <= 1'b0;
      din_q        <= 1'b0;
      phase_q      <= 1'b0;
      bit_q        <= 4'd0;
      div_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      sent_blank_q <= sent_blank_d;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      din_q        <= din_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
    end
  end

  // Remaining frame bits; only meaningful while shifting, so not reset.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign din       = din_q;
  assign init_done = init_done_q;
  assign busy      = (state_q == SHIFT) || (state_q == GAP);

endmodule

// File: tb/tb_max7219_cmd_scheduler.sv
// Testbench for max7219_cmd_scheduler: decodes frames off the serial pins and
// compares them with frames predicted from the command rules.
module tb_max7219_cmd_scheduler;

  localparam int CLK_DIV   = 2;
  localparam int FRAME_LEN = 32 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank = 1'b0;
  logic       int_req = 1'b0;
  logic [3:0] int_level = 4'h0;
  logic       int_ack;
  logic       dig_req = 1'b0;
  logic [3:0] dig_addr = 4'h0;
  logic [7:0] dig_data = 8'h00;
  logic       dig_ack;
  logic       din, cs, sclk, init_done, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected frame order and last shutdown value sent.
  logic [15:0] exp_q[$];
  logic        exp_sent_blank = 1'b0;

  // Pin monitor state.
  int          gap_q[$];
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;
  logic [15:0] mon_sh = 16'h0;
  logic [15:0] mon_exp;
  int          mon_bits = 0, mon_low = 0, mon_high = 0;
  int          int_acks = 0, dig_acks = 0, pre_init_acks = 0, din_viol = 0;
  bit          abort_ok = 1'b0;
  int          cyc = 0;

  max7219_cmd_scheduler #(
    .CLK_DIV(CLK_DIV),
    .SCAN_LIMIT(8'h00),
    .INTENSITY_RST(4'h8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .blank(blank),
    .int_req(int_req),
    .int_level(int_level),
    .int_ack(int_ack),
    .dig_req(dig_req),
    .dig_addr(dig_addr),
    .dig_data(dig_data),
    .dig_ack(dig_ack),
    .din(din),
    .cs(cs),
    .sclk(sclk),
    .init_done(init_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Serial decoder and frame scoreboard, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (int_ack) int_acks++;
    if (dig_ack) dig_acks++;
    if ((int_ack || dig_ack) && !init_done) pre_init_acks++;
    if (!cs) begin
      if (prev_cs) begin
        gap_q.push_back(mon_high);
        mon_bits = 0;
        mon_low  = 0;
        mon_sh   = 16'h0;
      end
      mon_low++;
      if (sclk && !prev_sclk) begin
        mon_sh = {mon_sh[14:0], din};
        mon_bits++;
      end
      if (sclk && prev_sclk && (din !== prev_din)) din_viol++;
    end else begin
      if (!prev_cs && !(abort_ok && mon_bits != 16)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got %h (%0d bits) required no frame", mon_sh, mon_bits);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_sh !== mon_exp || mon_bits != 16) begin
            errors++;
            $display("FAIL frame_value got %h (%0d bits) required %h (16 bits)", mon_sh, mon_bits, mon_exp);
          end
        end
        checks++;
        if (mon_low != FRAME_LEN) begin
          errors++;
          $display("FAIL cs_low_time got %0d required %0d", mon_low, FRAME_LEN);
        end
      end
      if (!prev_cs) mon_high = 0;
      mon_high++;
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_din  = din;
  end

  task automatic push_init_frames();
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0901);
    exp_q.push_back(16'h0B00);
    exp_q.push_back(16'h0A08);
    exp_q.push_back({8'h0C, 7'h00, ~blank});
    exp_sent_blank = blank;
  endtask

  task automatic wait_quiet();
    int q = 0;
    for (int n = 0; n < 5000 && q < 8; n++) begin
      @(negedge clk);
      if (cs && !busy) q++;
      else q = 0;
    end
    checks++;
    if (q < 8) begin
      errors++;
      $display("FAIL quiet_timeout got %0d quiet cycles required 8", q);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_dig(input logic [3:0] a, input logic [7:0] d, output int seen);
    dig_addr = a;
    dig_data = d;
    dig_req  = 1'b1;
    seen     = 0;
    for (int n = 0; n < 5000 && seen == 0; n++) begin
      @(negedge clk);
      if (dig_ack) seen = 1;
    end
    @(posedge clk);
    #1 dig_req = 1'b0;
  endtask

  task automatic send_int(input logic [3:0] l, output int seen);
    int_level = l;
    int_req   = 1'b1;
    seen      = 0;
    for (int n = 0; n < 5000 && seen == 0; n++) begin
      @(negedge clk);
      if (int_ack) seen = 1;
    end
    @(posedge clk);
    #1 int_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    int_req  = 1'b1;
    dig_req  = 1'b1;
    dig_addr = 4'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (cs !== 1'b1 || sclk !== 1'b0 || din !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins got cs=%b sclk=%b din=%b required 1 0 0", cs, sclk, din);
    end
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got busy=%b init_done=%b required 0 0", busy, init_done);
    end
    checks++;
    if (int_ack !== 1'b0 || dig_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_acks got int_ack=%b dig_ack=%b required 0 0", int_ack, dig_ack);
    end
    @(posedge clk);
    #1;
    int_req = 1'b0;
  endtask

  task automatic test_init();
    int d0, bad, hi;
    dig_addr = 4'd0;
    dig_req  = 1'b1;
    gap_q.delete();
    push_init_frames();
    d0 = dig_acks;
    rst_n = 1'b1;
    for (int n = 0; n < 5000 && !init_done; n++) @(negedge clk);
    #1;
    hi = mon_high;
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_timeout got %b required 1", init_done);
    end
    checks++;
    if (hi != 2) begin
      errors++;
      $display("FAIL init_done_timing got %0d cs-high cycles required 2", hi);
    end
    checks++;
    if (pre_init_acks != 0) begin
      errors++;
      $display("FAIL ack_before_init got %0d required 0", pre_init_acks);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_frames_left got %0d required 0", exp_q.size());
    end
    bad = 0;
    for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 2) bad++;
    checks++;
    if (gap_q.size() != 5 || bad != 0) begin
      errors++;
      $display("FAIL init_gaps got %0d frames %0d bad gaps required 5 frames 0 bad", gap_q.size(), bad);
    end
    // Illegal-address digit request held through init: acked now, nothing sent.
    for (int n = 0; n < 50 && dig_acks == d0; n++) @(negedge clk);
    @(posedge clk);
    #1 dig_req = 1'b0;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy || !cs) bad++;
    end
    checks++;
    if (dig_acks - d0 != 1) begin
      errors++;
      $display("FAIL illegal_addr_ack got %0d pulses required 1", dig_acks - d0);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL illegal_addr_idle got %0d active cycles required 0", bad);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_hold got %b required 1", init_done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_digit();
    int seen, d0;
    d0 = dig_acks;
    exp_q.push_back(16'h0107);
    send_dig(4'd1, 8'h07, seen);
    wait_quiet();
    checks++;
    if (seen != 1 || dig_acks - d0 != 1) begin
      errors++;
      $display("FAIL digit_ack got %0d pulses required 1", dig_acks - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL digit_frame_missing got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int ia = -1, da = -1;
    gap_q.delete();
    exp_q.push_back(16'h0A0F);
    exp_q.push_back(16'h0103);
    int_level = 4'hF;
    dig_addr  = 4'd1;
    dig_data  = 8'h03;
    int_req   = 1'b1;
    dig_req   = 1'b1;
    for (int n = 0; n < 5000 && (ia < 0 || da < 0); n++) begin
      @(negedge clk);
      if (int_ack && ia < 0) ia = cyc;
      if (dig_ack && da < 0) da = cyc;
      @(posedge clk);
      #1;
      if (ia >= 0) int_req = 1'b0;
      if (da >= 0) dig_req = 1'b0;
    end
    int_req = 1'b0;
    dig_req = 1'b0;
    wait_quiet();
    checks++;
    if (ia < 0 || da < 0 || ia >= da) begin
      errors++;
      $display("FAIL simul_ack_order got int@%0d dig@%0d required int first", ia, da);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_frames_left got %0d required 0", exp_q.size());
    end
    checks++;
    if (gap_q.size() != 2 || gap_q[1] != 2) begin
      errors++;
      $display("FAIL simul_gap got %0d frames gap %0d required 2 frames gap 2", gap_q.size(), (gap_q.size() > 1) ? gap_q[1] : -1);
    end
  endtask

  task automatic test_blank();
    int seen;
    exp_q.push_back(16'h02AB);
    send_dig(4'd2, 8'hAB, seen);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 blank = 1'b1;
    exp_q.push_back(16'h0C00);
    exp_q.push_back(16'h0A03);
    exp_sent_blank = 1'b1;
    send_int(4'h3, seen);
    wait_quiet();
    checks++;
    if (seen != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL blank_priority got ack=%0d pending=%0d required 1 0", seen, exp_q.size());
    end
    // Short blank glitch inside a frame: no shutdown command expected.
    exp_q.push_back(16'h0355);
    send_dig(4'd3, 8'h55, seen);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 blank = 1'b0;
    repeat (3) @(posedge clk);
    #1 blank = 1'b1;
    wait_quiet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL blank_glitch got %0d pending required 0", exp_q.size());
    end
    blank = 1'b0;
    exp_q.push_back(16'h0C01);
    exp_sent_blank = 1'b0;
    wait_quiet();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL blank_restore got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    int seen, bad;
    logic [3:0] a;
    logic [7:0] d;
    logic       nb;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 4'($urandom_range(0, 15));
          d = 8'($urandom);
          if (a >= 4'd1 && a <= 4'd8) exp_q.push_back({4'h0, a, d});
          send_dig(a, d, seen);
          if (seen != 1) bad++;
        end
        2: begin
          a = 4'($urandom);
          exp_q.push_back({8'h0A, 4'h0, a});
          send_int(a, seen);
          if (seen != 1) bad++;
        end
        default: begin
          nb = 1'($urandom_range(0, 1));
          blank = nb;
          if (nb != exp_sent_blank) begin
            exp_q.push_back({8'h0C, 7'h00, ~nb});
            exp_sent_blank = nb;
          end
        end
      endcase
      wait_quiet();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_acks got %0d missing acks required 0", bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_frames_left got %0d required 0", exp_q.size());
    end
    blank = 1'b0;
    if (exp_sent_blank) exp_q.push_back(16'h0C01);
    exp_sent_blank = 1'b0;
    wait_quiet();
  endtask

  task automatic test_reset_midframe();
    int seen;
    exp_q.push_back(16'h0142);
    send_dig(4'd1, 8'h42, seen);
    for (int n = 0; n < 500 && mon_bits < 8; n++) @(negedge clk);
    abort_ok = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cs !== 1'b1 || sclk !== 1'b0 || din !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset_pins got cs=%b sclk=%b din=%b required 1 0 0", cs, sclk, din);
    end
    checks++;
    if (busy !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset_status got busy=%b init_done=%b required 0 0", busy, init_done);
    end
    repeat (3) @(negedge clk);
    exp_q.delete();
    push_init_frames();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 5000 && !init_done; n++) @(negedge clk);
    #1;
    abort_ok = 1'b0;
    checks++;
    if (init_done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reinit got init_done=%b pending=%0d required 1 0", init_done, exp_q.size());
    end
    wait_quiet();
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_digit();
    test_back_to_back();
    test_blank();
    test_random();
    test_reset_midframe();
    checks++;
    if (din_viol != 0) begin
      errors++;
      $display("FAIL din_while_sclk_high got %0d changes required 0", din_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_cmd_scheduler.md
MAX7219_CMD_SCHEDULER -- requirements
Module: max7219_cmd_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter SCAN_LIMIT, default 0, meaning the value written to register 0x0B.
REQ-003 SHALL have parameter INTENSITY_RST, default 8, meaning the 4-bit intensity value written during init.
REQ-004 SHALL have port clk  in  1  single clock for all logic; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port blank  in  1  1 = display shutdown requested, 0 = display on.
REQ-007 SHALL have port int_req  in  1  intensity update request, held high until acknowledged.
REQ-008 SHALL have port int_level  in  4  requested intensity, sampled at int_ack.
REQ-009 SHALL have port int_ack  out  1  one-cycle pulse: intensity request accepted.
REQ-010 SHALL have port dig_req  in  1  digit update request, held high until acknowledged.
REQ-011 SHALL have port dig_addr  in  4  MAX7219 digit register address (1..8).
REQ-012 SHALL have port dig_data  in  8  digit register data, sampled with dig_addr at dig_ack.
REQ-013 SHALL have port dig_ack  out  1  one-cycle pulse: digit request accepted.
REQ-014 SHALL have port din / cs / sclk  out  1 each  MAX7219 serial data, chip select (active low), serial clock.
REQ-015 SHALL have port init_done  out  1  high once the init sequence has completed.
REQ-016 SHALL have port busy  out  1  high while a frame is being shifted or the gap is running.

Function
REQ-017 Frame: 16 bits {4'h0, addr[3:0], data[7:0]}, shifted MSB first.
REQ-018 Transmission: cs falls; din set up; sclk low CLK_DIV cycles, then high CLK_DIV cycles per bit; din changes only while sclk is low.
REQ-019 Transmission end: after the 16th sclk high phase, sclk returns low and cs rises; cs then stays high for exactly 2 clk cycles (gap) before the next frame can start.
REQ-020 Frame duration: cs-low time SHALL be exactly 32*CLK_DIV cycles, with busy high from cs fall through the end of the gap.
REQ-021 FSM states: RESET_WAIT, INIT, IDLE, SHIFT, GAP.
REQ-022 INIT sequence, in order: 0x0F00 (test off), 0x0901 (BCD decode digit 0), 0x0B{SCAN_LIMIT}, 0x0A{INTENSITY_RST}, 0x0C{~blank}.
REQ-023 Exit from reset: RESET_WAIT lasts 4 cycles, then INIT starts.
REQ-024 init_done SHALL rise in the cycle after the final init gap ends, and remain high until reset.
REQ-025 Requests before init_done: int_req and dig_req are not acknowledged.
REQ-026 Blank tracking: the scheduler holds a sent_blank register; a mismatch between blank and sent_blank is a pending shutdown command 0x0C{~blank}.
REQ-027 Arbitration in IDLE, evaluated every cycle, fixed priority: shutdown mismatch > int_req > dig_req.
REQ-028 Grant: the frame is latched and SHIFT entered in the same cycle; that cycle also pulses the matching ack for exactly one cycle (none for shutdown) and updates sent_blank for a shutdown grant.
REQ-029 Intensity frame: 0x0A{4'h0,int_level}.
REQ-030 Digit frame: {4'h0,dig_addr,dig_data}.
REQ-031 Illegal dig_addr (0 or >8): still acknowledged; no frame is sent; the scheduler stays in IDLE.
REQ-032 Requests during SHIFT/GAP wait, with no ack; they are arbitrated on the first IDLE cycle.
REQ-033 blank toggling twice within one frame SHALL produce no extra command if blank equals sent_blank at arbitration.
REQ-034 Simultaneous requests: int_req and dig_req both high gives int first, dig after the gap.
REQ-035 Idle output levels: cs=1, sclk=0, din=0.

Reset
REQ-036 rst_n low, asynchronously, in any state including mid-frame: cs=1, sclk=0, din=0, int_ack=0, dig_ack=0, busy=0, init_done=0, state=RESET_WAIT, sent_blank=0.
REQ-037 The aborted frame SHALL NOT be resumed; the full INIT sequence reruns after rst_n rises.

Verification
REQ-038 Reset release with blank=0, CLK_DIV=2: 5 frames 0x0F00, 0x0901, 0x0B00, 0x0A08, 0x0C01; each cs-low time 64 cycles; init_done then rises.
REQ-039 After init, dig_req with addr=1, data=0x07: dig_ack pulses once; frame 0x0107 is sent MSB first, sampled on sclk rising edge.
REQ-040 int_req (level=0xF) and dig_req (addr=1, data=0x03) raised in the same cycle: frames 0x0A0F then 0x0103, separated by a 2-cycle cs-high gap.
REQ-041 blank 0->1 during a digit frame, with int_req pending: 0x0C00 is sent before 0x0A frame; a blank pulse of 3 cycles inside a frame produces no 0x0C frame.
REQ-042 rst_n asserted at bit 8 of a frame: cs high and sclk low immediately (async); after release the 5-frame init repeats.
REQ-043 dig_addr=0 request: dig_ack pulses; busy stays 0; no cs activity.
